button_conditioner: RTL and testbench

Input conditioner for the nibble processor's `pushbuttons[3:0]` port. It takes four raw, asynchronous, bouncing switch inputs and synchronises each one to `clk`. It debounces each input with its own counter and presents either clean levels or sticky press flags to the core's IN data path. The flags are cleared by the IN-strobe (decoder command bit 2) so that the program reads each press exactly once.

---
 rtl/uP_pkg.sv | 17 +
 rtl/button_conditioner_debounce_bit.sv | 72 +++++++
 rtl/button_conditioner.sv | 84 ++++++++
 tb/tb_button_conditioner.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uP_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uP_pkg
// Description : Constants shared by the nibble processor and its peripherals.
//               DATA_W              - width of the core data bus
//               DEBOUNCE_CYCLES_DEF - default debounce qualification length
//               CMD_IN              - decoder command bit that strobes IN
// Revision    : 1.0 - initial release
// ============================================================================
package uP_pkg;

  localparam int DATA_W              = 4;
  localparam int DEBOUNCE_CYCLES_DEF = 16;
  localparam int CMD_IN              = 2;

endpackage : uP_pkg
`default_nettype wire

// File: rtl/button_conditioner_debounce_bit.sv
`default_nettype none
// ============================================================================
// Module      : debounce_bit
// Description : Two-flop synchroniser followed by a consecutive-sample
//               debounce counter for a single switch input.
// Ports       : clk      - system clock
//               reset    - asynchronous, active-high
//               raw_i    - raw switch input, asynchronous to clk
//               stable_o - debounced level (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_bit
  import uP_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic stable_o
);

  localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q;
  logic             s2_q;
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Synchroniser: only s2_q is allowed to feed any downstream logic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= raw_i;
      s2_q <= s1_q;
    end
  end

  // Any single cycle of agreement restarts qualification; the counter is
  // cleared on acceptance, so it can never wrap.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (s2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = s2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule : debounce_bit
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : Synchronises and debounces the pushbutton inputs, generates
//               rise pulses and sticky press flags, and selects the value
//               presented on the core's IN data path.
// Ports       : clk         - system clock (processor clock)
//               reset       - asynchronous, active-high
//               btn_raw     - raw switch inputs, asynchronous to clk
//               rd_ack      - IN strobe (decoder command bit CMD_IN)
//               btn_level   - debounced level per button
//               btn_rise    - one-cycle pulse per debounced 0->1 transition
//               btn_press   - sticky press flags, cleared by rd_ack
//               pushbuttons - STICKY ? btn_press : btn_level
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner
  import uP_pkg::*;
#(
  parameter int WIDTH           = DATA_W,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter bit STICKY          = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] btn_raw,
  input  logic             rd_ack,
  output logic [WIDTH-1:0] btn_level,
  output logic [WIDTH-1:0] btn_rise,
  output logic [WIDTH-1:0] btn_press,
  output logic [WIDTH-1:0] pushbuttons
);

  logic [WIDTH-1:0] level_w;
  logic [WIDTH-1:0] level_prev_q;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] press_q;
  logic [WIDTH-1:0] press_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk      (clk),
      .reset    (reset),
      .raw_i    (btn_raw[i]),
      .stable_o (level_w[i])
    );
  end

  // A new rise is OR-ed in after the clear so a press landing on the same
  // edge as rd_ack survives and is read by the next IN instruction.
  always_comb begin
    rise_d  = level_w & ~level_prev_q;
    press_d = rise_d | (press_q & ~{WIDTH{rd_ack}});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_prev_q <= '0;
      rise_q       <= '0;
      press_q      <= '0;
    end else begin
      level_prev_q <= level_w;
      rise_q       <= rise_d;
      press_q      <= press_d;
    end
  end

  assign btn_level = level_w;
  assign btn_rise  = rise_q;
  assign btn_press = press_q;

  // The core latches data during the rd_ack cycle, so it sees the pre-clear
  // flags; both sources are pure register outputs.
  if (STICKY) begin : g_sticky
    assign pushbuttons = press_q;
  end else begin : g_level
    assign pushbuttons = level_w;
  end

endmodule : button_conditioner
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_conditioner
// Description : Self-checking bench for button_conditioner (DEBOUNCE_CYCLES=4)
//               with a sticky and a level-mode instance on shared inputs.
//               A reference model predicts every cycle's outputs into a
//               queue; a monitor pops and compares. Directed scenarios add
//               explicit constant checks, followed by randomized bouncing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

  localparam int W = 4;
  localparam int D = 4;

  logic         clk;
  logic         reset;
  logic [W-1:0] btn_raw;
  logic         rd_ack;
  logic [W-1:0] lvl_s, rise_s, press_s, pb_s;
  logic [W-1:0] lvl_l, rise_l, press_l, pb_l;

  int n_tests = 0;
  int n_fail  = 0;

  button_conditioner #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .STICKY(1'b1)) dut (
    .clk (clk), .reset (reset), .btn_raw (btn_raw), .rd_ack (rd_ack),
    .btn_level (lvl_s), .btn_rise (rise_s), .btn_press (press_s),
    .pushbuttons (pb_s)
  );

  button_conditioner #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .STICKY(1'b0)) dut_lvl (
    .clk (clk), .reset (reset), .btn_raw (btn_raw), .rd_ack (rd_ack),
    .btn_level (lvl_l), .btn_rise (rise_l), .btn_press (press_l),
    .pushbuttons (pb_l)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // Synchronised value = raw delayed two edges. A level is accepted once the
  // last D synchronised samples all disagree with the current level.
  typedef struct packed {
    logic [W-1:0] level;
    logic [W-1:0] rise;
    logic [W-1:0] press;
  } exp_t;

  exp_t         exp_q[$];
  logic         hist[W][$];
  logic [W-1:0] m_sync1, m_sync2, m_level, m_level_before, m_rise, m_press;
  logic [W-1:0] m_level_new;
  logic         all_diff;

  initial begin
    m_sync1 = '0; m_sync2 = '0; m_level = '0;
    m_level_before = '0; m_rise = '0; m_press = '0;
  end

  always @(posedge clk) begin
    if (reset) begin
      m_sync1 = '0; m_sync2 = '0; m_level = '0;
      m_level_before = '0; m_rise = '0; m_press = '0;
      for (int b = 0; b < W; b++) hist[b].delete();
    end else begin
      m_level_new = m_level;
      for (int b = 0; b < W; b++) begin
        hist[b].push_back(m_sync2[b]);
        if (hist[b].size() > D) void'(hist[b].pop_front());
        if (hist[b].size() == D) begin
          all_diff = 1'b1;
          for (int k = 0; k < D; k++)
            if (hist[b][k] == m_level[b]) all_diff = 1'b0;
          if (all_diff) m_level_new[b] = ~m_level[b];
        end
      end
      // rise: level went 0->1 on the previous edge; press set beats clear
      m_rise         = m_level & ~m_level_before;
      m_press        = rd_ack ? m_rise : (m_press | m_rise);
      m_level_before = m_level;
      m_level        = m_level_new;
      m_sync2        = m_sync1;
      m_sync1        = btn_raw;
    end
    exp_q.push_back('{level: m_level, rise: m_rise, press: m_press});
  end

  // ---------------- monitor / scoreboard ----------------
  exp_t mon_e;

  always @(posedge clk) begin
    #1;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty at %0t", $time);
    end else begin
      mon_e = exp_q.pop_front();
      if (lvl_s !== mon_e.level || rise_s !== mon_e.rise ||
          press_s !== mon_e.press || pb_s !== mon_e.press ||
          lvl_l !== mon_e.level || rise_l !== mon_e.rise ||
          press_l !== mon_e.press || pb_l !== mon_e.level) begin
        n_fail++;
        $display("FAIL cycle_check t=%0t got lvl=%h rise=%h press=%h pb=%h lvlL=%h pbL=%h expected lvl=%h rise=%h press=%h",
                 $time, lvl_s, rise_s, press_s, pb_s, lvl_l, pb_l,
                 mon_e.level, mon_e.rise, mon_e.press);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [W-1:0] raw, input logic ack,
                       input logic rst);
    @(negedge clk);
    btn_raw = raw;
    rd_ack  = ack;
    reset   = rst;
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  int hold[W];

  initial begin
    reset   = 1'b1;
    btn_raw = '0;
    rd_ack  = 1'b0;

    // Reset with all buttons held
    drive(4'hF, 1'b0, 1'b1); edges(1);
    chk("reset_level", lvl_s, 4'h0);
    chk("reset_rise", rise_s, 4'h0);
    chk("reset_press", press_s, 4'h0);
    chk("reset_pb", pb_s, 4'h0);
    chk("reset_pb_lvl", pb_l, 4'h0);
    drive(4'hF, 1'b0, 1'b0); edges(5);
    chk("rel_level_e5", lvl_s, 4'h0);
    edges(1);
    chk("rel_level_e6", lvl_s, 4'hF);
    edges(1);
    chk("rel_rise_e7", rise_s, 4'hF);
    chk("rel_press_e7", press_s, 4'hF);
    drive(4'hF, 1'b1, 1'b0); edges(1);
    chk("rel_ack_clear", press_s, 4'h0);
    drive(4'hF, 1'b0, 1'b0); edges(8);
    chk("rel_hold_no_reset", press_s, 4'h0);

    // Clean press of bit 0
    drive(4'h0, 1'b0, 1'b1); edges(1);
    drive(4'h1, 1'b0, 1'b0); edges(5);
    chk("clean_level_e5", lvl_s, 4'h0);
    edges(1);
    chk("clean_level_e6", lvl_s, 4'h1);
    chk("clean_rise_e6", rise_s, 4'h0);
    edges(1);
    chk("clean_rise_e7", rise_s, 4'h1);
    chk("clean_press_e7", press_s, 4'h1);
    edges(1);
    chk("clean_rise_e8", rise_s, 4'h0);
    chk("clean_press_e8", press_s, 4'h1);

    // Bounce on bit 1: 1,0,1,0 then hold 1
    drive(4'h0, 1'b0, 1'b1); edges(1);
    drive(4'h2, 1'b0, 1'b0); edges(1);
    drive(4'h0, 1'b0, 1'b0); edges(1);
    drive(4'h2, 1'b0, 1'b0); edges(1);
    drive(4'h0, 1'b0, 1'b0); edges(1);
    chk("bounce_no_level", lvl_s, 4'h0);
    drive(4'h2, 1'b0, 1'b0); edges(5);
    chk("bounce_level_e5", lvl_s, 4'h0);
    chk("bounce_rise_e5", rise_s, 4'h0);
    edges(1);
    chk("bounce_level_e6", lvl_s, 4'h2);
    edges(1);
    chk("bounce_rise_e7", rise_s, 4'h2);
    edges(1);
    chk("bounce_rise_e8", rise_s, 4'h0);
    chk("bounce_press", press_s, 4'h2);

    // Ack clears press = 5
    drive(4'h0, 1'b0, 1'b1); edges(1);
    drive(4'h5, 1'b0, 1'b0); edges(7);
    chk("ack_press_before", press_s, 4'h5);
    chk("ack_pb_before", pb_s, 4'h5);
    drive(4'h5, 1'b1, 1'b0); edges(1);
    chk("ack_press_after", press_s, 4'h0);
    drive(4'h5, 1'b0, 1'b0); edges(8);
    chk("ack_press_held", press_s, 4'h0);
    chk("ack_level_held", lvl_s, 4'h5);

    // Simultaneous rise (bit 3) and rd_ack while bit 2 is set
    drive(4'h0, 1'b0, 1'b1); edges(1);
    drive(4'h4, 1'b0, 1'b0); edges(7);
    chk("simul_press_b2", press_s, 4'h4);
    drive(4'hC, 1'b0, 1'b0); edges(6);
    chk("simul_level", lvl_s, 4'hC);
    drive(4'hC, 1'b1, 1'b0); edges(1);
    chk("simul_press", press_s, 4'h8);
    chk("simul_rise", rise_s, 4'h8);
    drive(4'hC, 1'b0, 1'b0); edges(1);
    chk("simul_press_kept", press_s, 4'h8);

    // Reset while cnt = 2, then full re-qualification
    drive(4'h0, 1'b0, 1'b1); edges(1);
    drive(4'h1, 1'b0, 1'b0); edges(4);
    drive(4'h1, 1'b0, 1'b1); edges(1);
    chk("midrst_level", lvl_s, 4'h0);
    drive(4'h1, 1'b0, 1'b0); edges(5);
    chk("midrst_level_e5", lvl_s, 4'h0);
    chk("midrst_pb_lvl_e5", pb_l, 4'h0);
    edges(1);
    chk("midrst_level_e6", lvl_s, 4'h1);
    chk("midrst_pb_lvl_e6", pb_l, 4'h1);

    // Randomized bouncing, acks and occasional resets
    for (int b = 0; b < W; b++) hold[b] = $urandom_range(1, 8);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      for (int b = 0; b < W; b++) begin
        if (hold[b] == 0) begin
          btn_raw[b] = ~btn_raw[b];
          hold[b] = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 3)
                                                : $urandom_range(3, 12);
        end else begin
          hold[b]--;
        end
      end
      rd_ack = ($urandom_range(0, 7) == 0);
      reset  = ($urandom_range(0, 299) == 0);
    end
    drive(btn_raw, 1'b0, 1'b0);
    edges(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_button_conditioner
`default_nettype wire
